dmem_arbiter_fsm: RTL and testbench

- Sequences the single data-memory port between the load reservation station and the committed-store path.
- Accepts one request at a time: either a load candidate or the head store.
- Holds the memory request stable until the memory responds.
- Signals completion back to the requester: `load_rs_pop` with an index for loads, `store_rs_pop` for stores.
- Squashes in-flight load responses across `move_flush`.

---
 rtl/rv32i_types.sv | 13 +
 rtl/dmem_arbiter_fsm.sv | 98 +++++++++
 tb/tb_dmem_arbiter_fsm.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types; holds the data-memory arbiter state encoding.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_WAIT  = 2'd1,
      STORE_WAIT = 2'd2,
      LOAD_DRAIN = 2'd3
   } dmem_fsm_state_t;

   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_arbiter_fsm.sv
// Arbitrates the single data-memory port between the load RS and the committed store,
// holding each request until the memory responds and squashing loads across a flush.
module dmem_arbiter_fsm
   import rv32i_types::*;
#(
   parameter int unsigned LOAD_RS_DEPTH = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     move_flush,
   input  logic                     dmem_r_rqst,
   input  logic [LOAD_RS_DEPTH-1:0] load_rs_idx_rqst,
   input  logic [31:0]              arbiter_load_rs_addr,
   input  logic [3:0]               arbiter_load_rs_rmask,
   input  logic                     store_w_rqst,
   input  logic [31:0]              store_addr,
   input  logic [3:0]               store_wmask,
   input  logic [31:0]              store_wdata,
   output logic                     load_rs_pop,
   output logic [LOAD_RS_DEPTH-1:0] load_rs_idx_executing,
   output logic                     store_rs_pop,
   output logic [31:0]              dmem_addr,
   output logic [3:0]               dmem_rmask,
   output logic [3:0]               dmem_wmask,
   output logic [31:0]              dmem_wdata,
   input  logic                     dmem_resp,
   output logic                     dmem_busy
);

   dmem_fsm_state_t state, state_next;

   logic launch_store;
   logic launch_load;

   // Stores win: the committed store is the oldest instruction and blocks commit.
   assign launch_store = (state == IDLE) && store_w_rqst;
   assign launch_load  = (state == IDLE) && !store_w_rqst && dmem_r_rqst && !move_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (launch_store)     state_next = STORE_WAIT;
            else if (launch_load) state_next = LOAD_WAIT;
         end
         LOAD_WAIT: begin
            if (dmem_resp)       state_next = IDLE;
            else if (move_flush) state_next = LOAD_DRAIN;
         end
         STORE_WAIT: begin
            if (dmem_resp) state_next = IDLE;
         end
         LOAD_DRAIN: begin
            if (dmem_resp) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      load_rs_pop  = (state == LOAD_WAIT) && dmem_resp && !move_flush;
      store_rs_pop = (state == STORE_WAIT) && dmem_resp;
      dmem_busy    = (state != IDLE);
   end

   // Request-hold registers: loaded only on launch, masks dropped on the response cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_addr             <= '0;
         dmem_rmask            <= '0;
         dmem_wmask            <= '0;
         dmem_wdata            <= '0;
         load_rs_idx_executing <= '0;
      end else if (launch_store) begin
         dmem_addr  <= store_addr & WORD_ALIGN_MASK;
         dmem_wmask <= store_wmask;
         dmem_wdata <= store_wdata;
         dmem_rmask <= '0;
      end else if (launch_load) begin
         dmem_addr             <= arbiter_load_rs_addr & WORD_ALIGN_MASK;
         dmem_rmask            <= arbiter_load_rs_rmask;
         dmem_wmask            <= '0;
         load_rs_idx_executing <= load_rs_idx_rqst;
      end else if ((state != IDLE) && dmem_resp) begin
         dmem_rmask <= '0;
         dmem_wmask <= '0;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter_fsm.sv
// Directed bench for dmem_arbiter_fsm: arbitration, hold, flush squash, async reset, cadence.
module tb_dmem_arbiter_fsm;

   localparam int unsigned D = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          move_flush;
   logic          dmem_r_rqst;
   logic [D-1:0]  load_rs_idx_rqst;
   logic [31:0]   arbiter_load_rs_addr;
   logic [3:0]    arbiter_load_rs_rmask;
   logic          store_w_rqst;
   logic [31:0]   store_addr;
   logic [3:0]    store_wmask;
   logic [31:0]   store_wdata;
   logic          load_rs_pop;
   logic [D-1:0]  load_rs_idx_executing;
   logic          store_rs_pop;
   logic [31:0]   dmem_addr;
   logic [3:0]    dmem_rmask;
   logic [3:0]    dmem_wmask;
   logic [31:0]   dmem_wdata;
   logic          dmem_resp;
   logic          dmem_busy;

   int unsigned total = 0;
   int unsigned bad   = 0;

   dmem_arbiter_fsm #(.LOAD_RS_DEPTH(D)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .move_flush            (move_flush),
      .dmem_r_rqst           (dmem_r_rqst),
      .load_rs_idx_rqst      (load_rs_idx_rqst),
      .arbiter_load_rs_addr  (arbiter_load_rs_addr),
      .arbiter_load_rs_rmask (arbiter_load_rs_rmask),
      .store_w_rqst          (store_w_rqst),
      .store_addr            (store_addr),
      .store_wmask           (store_wmask),
      .store_wdata           (store_wdata),
      .load_rs_pop           (load_rs_pop),
      .load_rs_idx_executing (load_rs_idx_executing),
      .store_rs_pop          (store_rs_pop),
      .dmem_addr             (dmem_addr),
      .dmem_rmask            (dmem_rmask),
      .dmem_wmask            (dmem_wmask),
      .dmem_wdata            (dmem_wdata),
      .dmem_resp             (dmem_resp),
      .dmem_busy             (dmem_busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n = 1'b0; move_flush = 1'b0; dmem_r_rqst = 1'b0; load_rs_idx_rqst = '0;
      arbiter_load_rs_addr = '0; arbiter_load_rs_rmask = '0; store_w_rqst = 1'b0;
      store_addr = '0; store_wmask = '0; store_wdata = '0; dmem_resp = 1'b0;
      step(); step();
      check_eq("rst_addr",  dmem_addr,  32'h0);
      check_eq("rst_rmask", dmem_rmask, 32'h0);
      check_eq("rst_wmask", dmem_wmask, 32'h0);
      check_eq("rst_wdata", dmem_wdata, 32'h0);
      check_eq("rst_idx",   load_rs_idx_executing, 32'h0);
      check_eq("rst_busy",  dmem_busy,  32'h0);
      check_eq("rst_pops",  {load_rs_pop, store_rs_pop}, 32'h0);
      rst_n = 1'b1;
      step();

      // Load only, 3-cycle latency
      dmem_r_rqst = 1'b1; load_rs_idx_rqst = 3'd5; arbiter_load_rs_addr = 32'h1006; arbiter_load_rs_rmask = 4'b1100;
      step();
      dmem_r_rqst = 1'b0;
      check_eq("ld_addr",  dmem_addr,  32'h1004);
      check_eq("ld_rmask", dmem_rmask, 32'hC);
      check_eq("ld_wmask", dmem_wmask, 32'h0);
      check_eq("ld_busy",  dmem_busy,  32'h1);
      check_eq("ld_nopop", load_rs_pop, 32'h0);
      step(); step();
      check_eq("ld_hold_addr", dmem_addr, 32'h1004);
      dmem_resp = 1'b1; settle();
      check_eq("ld_pop",      load_rs_pop, 32'h1);
      check_eq("ld_pop_idx",  load_rs_idx_executing, 32'h5);
      check_eq("ld_resp_rm",  dmem_rmask, 32'hC);
      check_eq("ld_no_spop",  store_rs_pop, 32'h0);
      step();
      dmem_resp = 1'b0;
      check_eq("ld_after_rm",   dmem_rmask, 32'h0);
      check_eq("ld_after_busy", dmem_busy, 32'h0);
      check_eq("ld_after_pop",  load_rs_pop, 32'h0);

      // Store beats load, then load after one idle cycle
      store_w_rqst = 1'b1; store_addr = 32'h2000; store_wmask = 4'b1111; store_wdata = 32'hDEADBEEF;
      dmem_r_rqst = 1'b1; load_rs_idx_rqst = 3'd4; arbiter_load_rs_addr = 32'h3001; arbiter_load_rs_rmask = 4'b0011;
      step();
      store_w_rqst = 1'b0;
      check_eq("st_addr",  dmem_addr,  32'h2000);
      check_eq("st_wmask", dmem_wmask, 32'hF);
      check_eq("st_wdata", dmem_wdata, 32'hDEADBEEF);
      check_eq("st_rmask", dmem_rmask, 32'h0);
      step();
      dmem_resp = 1'b1; settle();
      check_eq("st_spop",  store_rs_pop, 32'h1);
      check_eq("st_lpop",  load_rs_pop, 32'h0);
      step();
      dmem_resp = 1'b0;
      check_eq("st_idle_busy",  dmem_busy, 32'h0);
      check_eq("st_idle_wmask", dmem_wmask, 32'h0);
      step();
      dmem_r_rqst = 1'b0;
      check_eq("st2ld_addr",  dmem_addr,  32'h3000);
      check_eq("st2ld_rmask", dmem_rmask, 32'h3);
      check_eq("st2ld_idx",   load_rs_idx_executing, 32'h4);
      dmem_resp = 1'b1; settle();
      check_eq("st2ld_pop", load_rs_pop, 32'h1);
      step();
      dmem_resp = 1'b0;

      // Flush in IDLE blocks a load launch
      dmem_r_rqst = 1'b1; move_flush = 1'b1; load_rs_idx_rqst = 3'd6; arbiter_load_rs_addr = 32'h50; arbiter_load_rs_rmask = 4'hF;
      step();
      dmem_r_rqst = 1'b0; move_flush = 1'b0;
      check_eq("idleflush_busy",  dmem_busy, 32'h0);
      check_eq("idleflush_rmask", dmem_rmask, 32'h0);

      // Flush mid-load: drain, no pop
      dmem_r_rqst = 1'b1; load_rs_idx_rqst = 3'd2; arbiter_load_rs_addr = 32'h40; arbiter_load_rs_rmask = 4'hF;
      step();
      dmem_r_rqst = 1'b0;
      check_eq("fl_busy", dmem_busy, 32'h1);
      move_flush = 1'b1; settle();
      check_eq("fl_nopop0", load_rs_pop, 32'h0);
      step();
      move_flush = 1'b0;
      check_eq("fl_drain_rmask", dmem_rmask, 32'hF);
      check_eq("fl_drain_busy",  dmem_busy, 32'h1);
      step();
      dmem_resp = 1'b1; settle();
      check_eq("fl_resp_nopop", load_rs_pop, 32'h0);
      step();
      dmem_resp = 1'b0;
      check_eq("fl_end_busy",  dmem_busy, 32'h0);
      check_eq("fl_end_rmask", dmem_rmask, 32'h0);

      // Flush coincident with response drops it
      dmem_r_rqst = 1'b1; load_rs_idx_rqst = 3'd1; arbiter_load_rs_addr = 32'h60; arbiter_load_rs_rmask = 4'h1;
      step();
      dmem_r_rqst = 1'b0;
      dmem_resp = 1'b1; move_flush = 1'b1; settle();
      check_eq("flresp_nopop", load_rs_pop, 32'h0);
      step();
      dmem_resp = 1'b0; move_flush = 1'b0;
      check_eq("flresp_busy", dmem_busy, 32'h0);

      // Flush during store does not cancel it
      store_w_rqst = 1'b1; store_addr = 32'h200B; store_wmask = 4'b0110; store_wdata = 32'h12345678;
      step();
      store_w_rqst = 1'b0; move_flush = 1'b1;
      step();
      move_flush = 1'b0;
      check_eq("stfl_addr",  dmem_addr,  32'h2008);
      check_eq("stfl_wmask", dmem_wmask, 32'h6);
      check_eq("stfl_busy",  dmem_busy,  32'h1);
      dmem_resp = 1'b1; move_flush = 1'b1; settle();
      check_eq("stfl_spop", store_rs_pop, 32'h1);
      step();
      dmem_resp = 1'b0; move_flush = 1'b0;
      check_eq("stfl_busy_end", dmem_busy, 32'h0);

      // Response in IDLE is ignored
      dmem_resp = 1'b1; settle();
      check_eq("idleresp_pops", {load_rs_pop, store_rs_pop}, 32'h0);
      step();
      dmem_resp = 1'b0;
      check_eq("idleresp_busy", dmem_busy, 32'h0);

      // Async reset mid-LOAD_WAIT
      dmem_r_rqst = 1'b1; load_rs_idx_rqst = 3'd7; arbiter_load_rs_addr = 32'h88; arbiter_load_rs_rmask = 4'h1;
      step();
      dmem_r_rqst = 1'b0;
      check_eq("ar_busy_pre", dmem_busy, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar_addr",  dmem_addr,  32'h0);
      check_eq("ar_rmask", dmem_rmask, 32'h0);
      check_eq("ar_idx",   load_rs_idx_executing, 32'h0);
      check_eq("ar_busy",  dmem_busy,  32'h0);
      step();
      rst_n = 1'b1;
      step();
      dmem_resp = 1'b1; settle();
      check_eq("ar_resp_nopop", {load_rs_pop, store_rs_pop}, 32'h0);
      step();
      dmem_resp = 1'b0;

      // Back-to-back loads, 1-cycle latency
      dmem_r_rqst = 1'b1; load_rs_idx_rqst = 3'd1; arbiter_load_rs_addr = 32'h100; arbiter_load_rs_rmask = 4'hF;
      step();
      dmem_resp = 1'b1; settle();
      check_eq("b2b_pop1", load_rs_pop, 32'h1);
      check_eq("b2b_idx1", load_rs_idx_executing, 32'h1);
      step();
      dmem_resp = 1'b0; load_rs_idx_rqst = 3'd3; arbiter_load_rs_addr = 32'h202;
      check_eq("b2b_idle_busy", dmem_busy, 32'h0);
      check_eq("b2b_idle_pop",  load_rs_pop, 32'h0);
      step();
      dmem_r_rqst = 1'b0;
      check_eq("b2b_addr2", dmem_addr, 32'h200);
      dmem_resp = 1'b1; settle();
      check_eq("b2b_pop2", load_rs_pop, 32'h1);
      check_eq("b2b_idx2", load_rs_idx_executing, 32'h3);
      step();
      dmem_resp = 1'b0;
      check_eq("b2b_end_busy", dmem_busy, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
